// File: rtl/ccd_pattern_player_pkg.sv
// Shared encodings for the CCD pattern player: FSM states, command bytes,
// config register layout and a small clamping helper.
package ccd_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_LOAD = 2'd1,
        ST_PLAY = 2'd2,
        ST_DONE = 2'd3
    } state_t;

    localparam logic [7:0] CMD_START  = 8'hA0;
    localparam logic [7:0] CMD_STOP   = 8'h55;
    localparam logic [7:0] CMD_ABORT  = 8'h5A;
    localparam logic [7:0] CMD_REPLAY = 8'h5B;

    localparam int CFG_W         = 40;
    localparam int CFG_BLACK_LSB = 0;
    localparam int CFG_N_LSB     = 16;
    localparam int CFG_BLANK_LSB = 24;
    localparam int CFG_LINES_LSB = 32;

    localparam logic [7:0] N_MIN     = 8'd4;
    localparam logic [7:0] LINES_MIN = 8'd1;

    // Raise a config field to its minimum usable value.
    function automatic logic [7:0] at_least(input logic [7:0] v, input logic [7:0] lo);
        return (v < lo) ? lo : v;
    endfunction

endpackage

// File: rtl/ccd_pattern_player_ram.sv
// Pattern RAM: simple dual-port, synchronous write, registered read.
module pattern_ram #(
    parameter int DAC_W = 14,
    parameter int DEPTH = 256,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic             sys_clk,
    input  logic             wr_en,
    input  logic [AW-1:0]    wr_addr,
    input  logic [DAC_W-1:0] wr_data,
    input  logic [AW-1:0]    rd_addr,
    output logic [DAC_W-1:0] rd_data
);

    logic [DAC_W-1:0] mem [DEPTH];

    // Write port.
    always_ff @(posedge sys_clk) begin
        if (wr_en) begin
            mem[wr_addr] <= wr_data;
        end
    end

    // Registered read port, one cycle of latency.
    always_ff @(posedge sys_clk) begin
        rd_data <= mem[rd_addr];
    end

endmodule

// File: rtl/ccd_pattern_player.sv
// CCD pattern player: loads a pixel pattern from the master byte bus into RAM,
// then replays it to the DAC with the CCD timing set for a number of lines.
//
// state | meaning
// IDLE  | outputs parked, waiting for a start command
// LOAD  | assembling byte pairs into samples and writing the RAM
// PLAY  | replaying the pattern with pixel/line/frame timing
// DONE  | frame finished, RAM kept for replay
module ccd_pattern_player
    import ccd_pkg::*;
#(
    parameter int DAC_W = 14,
    parameter int DEPTH = 256,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic             sys_clk,
    input  logic             rst,
    input  logic [7:0]       master_data,
    input  logic             cfg_valid,
    input  logic             ctrl_valid,
    input  logic             sample_valid,
    output logic [DAC_W-1:0] dac_d,
    output logic             clk_fpga,
    output logic             shp_fpga,
    output logic             shd_fpga,
    output logic             clpdm_fpga,
    output logic             clpob_fpga,
    output logic             hd_fpga,
    output logic             vd_fpga,
    output logic             busy,
    output logic             done,
    output logic             overflow,
    output logic [AW:0]      pat_len,
    output logic [1:0]       state
);

    // Wide enough to compare pixel index, pattern length and blank count.
    localparam int CW = AW + 10;

    state_t           state_q;
    logic [CFG_W-1:0] cfg_sr;
    logic             mode_plain;
    logic             byte_hi;
    logic [7:0]       lo_byte;

    logic [7:0]       n_act;
    logic [7:0]       blank_act;
    logic [7:0]       lines_act;
    logic [DAC_W-1:0] black_act;

    logic [9:0]       inner;
    logic [AW:0]      pix;
    logic [7:0]       line;

    logic             wr_en;
    logic [DAC_W-1:0] wr_data;
    logic [AW-1:0]    rd_addr;
    logic [DAC_W-1:0] rd_data;

    logic             cmd_abort;
    logic             cmd_start;
    logic             cmd_stop;
    logic             cmd_replay;

    logic [9:0]       n_w;
    logic [9:0]       q1;
    logic [9:0]       q3;
    logic             last_inner;
    logic             last_pix;
    logic             last_line;
    logic             clp_next;

    assign cmd_abort  = ctrl_valid && (master_data == CMD_ABORT);
    assign cmd_start  = ctrl_valid && ((master_data & 8'hFE) == CMD_START);
    assign cmd_stop   = ctrl_valid && (master_data == CMD_STOP);
    assign cmd_replay = ctrl_valid && (master_data == CMD_REPLAY);

    assign n_w        = {2'b00, n_act};
    assign q1         = n_w >> 2;
    assign q3         = (n_w * 10'd3) >> 2;
    assign last_inner = (inner == (n_w << 1) - 10'd1);
    assign last_pix   = (pix == pat_len - 1'b1);
    assign last_line  = (line == lines_act - 8'd1);

    // Clamp is active on the leading pixels; the trailing 'blank' pixels are dark.
    assign clp_next = (CW'(blank_act) < CW'(pat_len)) &&
                      (CW'(pix) < CW'(pat_len) - CW'(blank_act));

    // A full RAM is flagged by the top bit of pat_len (pat_len == DEPTH).
    assign wr_en   = (state_q == ST_LOAD) && sample_valid && !ctrl_valid && byte_hi && !pat_len[AW];
    assign wr_data = DAC_W'({master_data, lo_byte});

    // Read the current pixel; on its last clock fetch the next one so it is ready at inner 0.
    always_comb begin
        rd_addr = '0;
        if (state_q == ST_PLAY) begin
            if (last_inner) begin
                rd_addr = last_pix ? '0 : AW'(pix + 1'b1);
            end else begin
                rd_addr = AW'(pix);
            end
        end
    end

    pattern_ram #(
        .DAC_W (DAC_W),
        .DEPTH (DEPTH),
        .AW    (AW)
    ) u_ram (
        .sys_clk (sys_clk),
        .wr_en   (wr_en),
        .wr_addr (pat_len[AW-1:0]),
        .wr_data (wr_data),
        .rd_addr (rd_addr),
        .rd_data (rd_data)
    );

    // FSM, config shift register, byte assembler, replay counters and output registers.
    always_ff @(posedge sys_clk) begin
        if (rst) begin
            state_q    <= ST_IDLE;
            cfg_sr     <= '0;
            mode_plain <= 1'b0;
            byte_hi    <= 1'b0;
            lo_byte    <= '0;
            pat_len    <= '0;
            overflow   <= 1'b0;
            n_act      <= '0;
            blank_act  <= '0;
            lines_act  <= '0;
            black_act  <= '0;
            inner      <= '0;
            pix        <= '0;
            line       <= '0;
            dac_d      <= '0;
            clk_fpga   <= 1'b1;
            shp_fpga   <= 1'b1;
            shd_fpga   <= 1'b1;
            clpdm_fpga <= 1'b0;
            hd_fpga    <= 1'b0;
            vd_fpga    <= 1'b0;
        end else begin
            if (cfg_valid && !ctrl_valid) begin
                cfg_sr <= {master_data, cfg_sr[CFG_W-1:8]};
            end

            if (cmd_abort) begin
                state_q    <= ST_IDLE;
                inner      <= '0;
                pix        <= '0;
                line       <= '0;
                dac_d      <= '0;
                clk_fpga   <= 1'b1;
                shp_fpga   <= 1'b1;
                shd_fpga   <= 1'b1;
                clpdm_fpga <= 1'b0;
                hd_fpga    <= 1'b0;
                vd_fpga    <= 1'b0;
            end else begin
                case (state_q)
                    ST_IDLE, ST_DONE: begin
                        if (cmd_start) begin
                            state_q    <= ST_LOAD;
                            mode_plain <= master_data[0];
                            pat_len    <= '0;
                            overflow   <= 1'b0;
                            byte_hi    <= 1'b0;
                        end else if (cmd_replay && (state_q == ST_DONE)) begin
                            // Config is sampled only here, on entry to PLAY.
                            state_q   <= ST_PLAY;
                            n_act     <= at_least(cfg_sr[CFG_N_LSB +: 8], N_MIN);
                            lines_act <= at_least(cfg_sr[CFG_LINES_LSB +: 8], LINES_MIN);
                            blank_act <= cfg_sr[CFG_BLANK_LSB +: 8];
                            black_act <= cfg_sr[CFG_BLACK_LSB +: DAC_W];
                            inner     <= '0;
                            pix       <= '0;
                            line      <= '0;
                        end
                    end

                    ST_LOAD: begin
                        if (cmd_stop) begin
                            if (pat_len != '0) begin
                                state_q   <= ST_PLAY;
                                n_act     <= at_least(cfg_sr[CFG_N_LSB +: 8], N_MIN);
                                lines_act <= at_least(cfg_sr[CFG_LINES_LSB +: 8], LINES_MIN);
                                blank_act <= cfg_sr[CFG_BLANK_LSB +: 8];
                                black_act <= cfg_sr[CFG_BLACK_LSB +: DAC_W];
                                inner     <= '0;
                                pix       <= '0;
                                line      <= '0;
                            end else begin
                                state_q <= ST_IDLE;
                            end
                        end else if (sample_valid && !ctrl_valid) begin
                            if (!byte_hi) begin
                                lo_byte <= master_data;
                                byte_hi <= 1'b1;
                            end else begin
                                byte_hi <= 1'b0;
                                if (pat_len[AW]) begin
                                    overflow <= 1'b1;
                                end else begin
                                    pat_len <= pat_len + 1'b1;
                                end
                            end
                        end
                    end

                    ST_PLAY: begin
                        if (inner == 10'd0) begin
                            clk_fpga   <= 1'b1;
                            hd_fpga    <= (pix == '0);
                            vd_fpga    <= (line == 8'd0);
                            clpdm_fpga <= clp_next;
                            dac_d      <= mode_plain ? rd_data : black_act;
                        end
                        if (inner == n_w) begin
                            clk_fpga <= 1'b0;
                            if (!mode_plain) begin
                                dac_d <= rd_data;
                            end
                        end
                        if (inner == q1) begin
                            shp_fpga <= 1'b0;
                        end
                        if (inner == q3) begin
                            shp_fpga <= 1'b1;
                        end
                        if (inner == n_w + q1) begin
                            shd_fpga <= 1'b0;
                        end
                        if (inner == n_w + q3) begin
                            shd_fpga <= 1'b1;
                        end

                        if (last_inner) begin
                            inner <= '0;
                            if (last_pix) begin
                                pix <= '0;
                                if (last_line) begin
                                    // Frame complete: park outputs, overriding any edge above.
                                    line       <= '0;
                                    state_q    <= ST_DONE;
                                    dac_d      <= '0;
                                    clk_fpga   <= 1'b1;
                                    shp_fpga   <= 1'b1;
                                    shd_fpga   <= 1'b1;
                                    clpdm_fpga <= 1'b0;
                                    hd_fpga    <= 1'b0;
                                    vd_fpga    <= 1'b0;
                                end else begin
                                    line <= line + 8'd1;
                                end
                            end else begin
                                pix <= pix + 1'b1;
                            end
                        end else begin
                            inner <= inner + 10'd1;
                        end
                    end

                    default: state_q <= ST_IDLE;
                endcase
            end
        end
    end

    assign clpob_fpga = clpdm_fpga;
    assign busy       = (state_q == ST_LOAD) || (state_q == ST_PLAY);
    assign done       = (state_q == ST_DONE);
    assign state      = state_q;

endmodule

// File: tb/tb_ccd_pattern_player.sv
// Directed testbench for ccd_pattern_player (DEPTH = 8, DAC_W = 14).
module tb_ccd_pattern_player;

    localparam int DAC_W = 14;
    localparam int DEPTH = 8;
    localparam int AW    = 3;
    localparam logic [6:0] IDLE_PINS = 7'b1110000;

    logic             sys_clk = 1'b0;
    logic             rst;
    logic [7:0]       master_data;
    logic             cfg_valid;
    logic             ctrl_valid;
    logic             sample_valid;
    logic [DAC_W-1:0] dac_d;
    logic             clk_fpga, shp_fpga, shd_fpga, clpdm_fpga, clpob_fpga, hd_fpga, vd_fpga;
    logic             busy, done, overflow;
    logic [AW:0]      pat_len;
    logic [1:0]       state;
    logic [6:0]       pins;

    int n_cmp = 0;
    int n_bad = 0;

    logic [15:0] ccd_s   [4]  = '{16'h0111, 16'h0222, 16'h0333, 16'h0444};
    logic [15:0] plain_s [4]  = '{16'h0ABC, 16'h3F01, 16'h1234, 16'h2D5E};
    logic [15:0] ov_s    [10] = '{16'h1001, 16'h1002, 16'h1003, 16'h1004, 16'h1005,
                                  16'h1006, 16'h1007, 16'h1008, 16'h1009, 16'h100A};

    always #5 sys_clk = ~sys_clk;

    assign pins = {clk_fpga, shp_fpga, shd_fpga, clpdm_fpga, clpob_fpga, hd_fpga, vd_fpga};

    ccd_pattern_player #(
        .DAC_W (DAC_W),
        .DEPTH (DEPTH),
        .AW    (AW)
    ) dut (
        .sys_clk      (sys_clk),
        .rst          (rst),
        .master_data  (master_data),
        .cfg_valid    (cfg_valid),
        .ctrl_valid   (ctrl_valid),
        .sample_valid (sample_valid),
        .dac_d        (dac_d),
        .clk_fpga     (clk_fpga),
        .shp_fpga     (shp_fpga),
        .shd_fpga     (shd_fpga),
        .clpdm_fpga   (clpdm_fpga),
        .clpob_fpga   (clpob_fpga),
        .hd_fpga      (hd_fpga),
        .vd_fpga      (vd_fpga),
        .busy         (busy),
        .done         (done),
        .overflow     (overflow),
        .pat_len      (pat_len),
        .state        (state)
    );

    // The master bus never asserts more than one valid at a time.
    always @(posedge sys_clk) begin
        assert (int'(cfg_valid) + int'(ctrl_valid) + int'(sample_valid) <= 1)
            else $error("FAIL bus_onehot: more than one valid asserted");
    end

    // kind: 0 = config, 1 = command, 2 = sample. Returns on the negedge after the sampling edge.
    task automatic send(input int kind, input logic [7:0] d);
        @(negedge sys_clk);
        master_data  = d;
        cfg_valid    = (kind == 0);
        ctrl_valid   = (kind == 1);
        sample_valid = (kind == 2);
        @(negedge sys_clk);
        cfg_valid    = 1'b0;
        ctrl_valid   = 1'b0;
        sample_valid = 1'b0;
    endtask

    task automatic send_cfg(input logic [15:0] black, input logic [7:0] n,
                            input logic [7:0] blank, input logic [7:0] lines);
        send(0, black[7:0]);
        send(0, black[15:8]);
        send(0, n);
        send(0, blank);
        send(0, lines);
    endtask

    task automatic send_sample(input logic [15:0] s);
        send(2, s[7:0]);
        send(2, s[15:8]);
    endtask

    // Full CCD frame: N = 8, 4 pixels, blank = 1, 2 lines, samples ccd_s.
    task automatic run_ccd_frame(input string tag);
        int j, i, p, l;
        logic [6:0] exp_pins;
        logic [13:0] exp_dac;
        logic [15:0] s;
        for (int c = 1; c <= 128; c++) begin
            @(negedge sys_clk);
            j = c - 1;
            i = j % 16;
            p = (j / 16) % 4;
            l = j / 64;
            if (c < 128) begin
                s = ccd_s[p];
                exp_pins = {i < 8, !(i >= 2 && i < 6), !(i >= 10 && i < 14),
                            p < 3, p < 3, p == 0, l == 0};
                exp_dac  = (i < 8) ? 14'h100 : s[13:0];
                n_cmp++;
                if (pins !== exp_pins || dac_d !== exp_dac || busy !== 1'b1 || done !== 1'b0) begin
                    n_bad++;
                    $display("FAIL %s c=%0d: got pins=%b dac=%h busy=%b done=%b, want pins=%b dac=%h busy=1 done=0",
                             tag, c, pins, dac_d, busy, done, exp_pins, exp_dac);
                end
            end else begin
                n_cmp++;
                if (pins !== IDLE_PINS || dac_d !== 14'd0 || state !== 2'd3 || done !== 1'b1 || busy !== 1'b0) begin
                    n_bad++;
                    $display("FAIL %s_done: got pins=%b dac=%h state=%0d done=%b busy=%b, want pins=%b dac=0 state=3 done=1 busy=0",
                             tag, pins, dac_d, state, done, busy, IDLE_PINS);
                end
            end
        end
    endtask

    task automatic test_reset();
        repeat (3) @(negedge sys_clk);
        rst = 1'b0;
        @(negedge sys_clk);
        n_cmp++;
        if (pins !== IDLE_PINS || dac_d !== 14'd0) begin
            n_bad++;
            $display("FAIL reset_pins: got pins=%b dac=%h, want pins=%b dac=0", pins, dac_d, IDLE_PINS);
        end
        n_cmp++;
        if (state !== 2'd0 || busy !== 1'b0 || done !== 1'b0) begin
            n_bad++;
            $display("FAIL reset_state: got state=%0d busy=%b done=%b, want 0 0 0", state, busy, done);
        end
        n_cmp++;
        if (pat_len !== 4'd0 || overflow !== 1'b0) begin
            n_bad++;
            $display("FAIL reset_len: got pat_len=%0d overflow=%b, want 0 0", pat_len, overflow);
        end
        send_sample(16'h3412);
        n_cmp++;
        if (pat_len !== 4'd0 || state !== 2'd0) begin
            n_bad++;
            $display("FAIL idle_sample_ignored: got pat_len=%0d state=%0d, want 0 0", pat_len, state);
        end
    endtask

    task automatic test_ccd();
        send_cfg(16'h0100, 8'd8, 8'd1, 8'd2);
        send(1, 8'hA0);
        for (int k = 0; k < 4; k++) send_sample(ccd_s[k]);
        n_cmp++;
        if (pat_len !== 4'd4 || state !== 2'd1 || busy !== 1'b1) begin
            n_bad++;
            $display("FAIL ccd_load: got pat_len=%0d state=%0d busy=%b, want 4 1 1", pat_len, state, busy);
        end
        send(1, 8'h55);
        run_ccd_frame("ccd");
    endtask

    task automatic test_replay();
        send(1, 8'h5B);
        run_ccd_frame("replay");
    endtask

    // N = 0 behaves as 4, lines = 0 plays one line, blank = 0 keeps the clamp on.
    task automatic test_plain();
        int j, i, p;
        logic [6:0] exp_pins;
        logic [15:0] s;
        send_cfg(16'h0000, 8'd0, 8'd0, 8'd0);
        send(1, 8'hA1);
        for (int k = 0; k < 4; k++) send_sample(plain_s[k]);
        send(1, 8'h55);
        for (int c = 1; c <= 32; c++) begin
            @(negedge sys_clk);
            j = c - 1;
            i = j % 8;
            p = j / 8;
            if (c < 32) begin
                s = plain_s[p];
                exp_pins = {i < 4, !(i >= 1 && i < 3), !(i >= 5 && i < 7), 1'b1, 1'b1, p == 0, 1'b1};
                n_cmp++;
                if (pins !== exp_pins || dac_d !== s[13:0]) begin
                    n_bad++;
                    $display("FAIL plain c=%0d: got pins=%b dac=%h, want pins=%b dac=%h",
                             c, pins, dac_d, exp_pins, s[13:0]);
                end
            end else begin
                n_cmp++;
                if (done !== 1'b1 || pins !== IDLE_PINS || dac_d !== 14'd0) begin
                    n_bad++;
                    $display("FAIL plain_done: got done=%b pins=%b dac=%h, want done=1 pins=%b dac=0",
                             done, pins, dac_d, IDLE_PINS);
                end
            end
        end
    endtask

    task automatic test_overflow();
        int j, i, p;
        logic [6:0] exp_pins;
        logic [15:0] s;
        send_cfg(16'h0000, 8'd4, 8'd8, 8'd1);
        send(1, 8'hA1);
        for (int k = 0; k < 10; k++) send_sample(ov_s[k]);
        n_cmp++;
        if (pat_len !== 4'd8 || overflow !== 1'b1 || state !== 2'd1) begin
            n_bad++;
            $display("FAIL overflow_flag: got pat_len=%0d overflow=%b state=%0d, want 8 1 1",
                     pat_len, overflow, state);
        end
        send(1, 8'h55);
        for (int c = 1; c <= 64; c++) begin
            @(negedge sys_clk);
            j = c - 1;
            i = j % 8;
            p = j / 8;
            if (c < 64) begin
                s = ov_s[p];
                exp_pins = {i < 4, !(i >= 1 && i < 3), !(i >= 5 && i < 7), 1'b0, 1'b0, p == 0, 1'b1};
                n_cmp++;
                if (pins !== exp_pins || dac_d !== s[13:0]) begin
                    n_bad++;
                    $display("FAIL overflow_play c=%0d: got pins=%b dac=%h, want pins=%b dac=%h",
                             c, pins, dac_d, exp_pins, s[13:0]);
                end
            end else begin
                n_cmp++;
                if (done !== 1'b1) begin
                    n_bad++;
                    $display("FAIL overflow_done: got done=%b, want 1", done);
                end
            end
        end
    endtask

    task automatic test_abort();
        send(1, 8'hA0);
        n_cmp++;
        if (pat_len !== 4'd0 || overflow !== 1'b0) begin
            n_bad++;
            $display("FAIL start_clears: got pat_len=%0d overflow=%b, want 0 0", pat_len, overflow);
        end
        send_cfg(16'h0100, 8'd8, 8'd1, 8'd2);
        for (int k = 0; k < 4; k++) send_sample(ccd_s[k]);
        send(1, 8'h55);
        for (int c = 1; c <= 97; c++) @(negedge sys_clk);
        n_cmp++;
        if (pins !== 7'b1111100 || dac_d !== 14'h100) begin
            n_bad++;
            $display("FAIL abort_pre: got pins=%b dac=%h, want pins=1111100 dac=100", pins, dac_d);
        end
        master_data = 8'h5A;
        ctrl_valid  = 1'b1;
        @(negedge sys_clk);
        ctrl_valid  = 1'b0;
        n_cmp++;
        if (pins !== IDLE_PINS || dac_d !== 14'd0 || busy !== 1'b0 || state !== 2'd0) begin
            n_bad++;
            $display("FAIL abort_idle: got pins=%b dac=%h busy=%b state=%0d, want pins=%b dac=0 busy=0 state=0",
                     pins, dac_d, busy, state, IDLE_PINS);
        end
        send(1, 8'h5B);
        @(negedge sys_clk);
        n_cmp++;
        if (state !== 2'd0 || clk_fpga !== 1'b1 || busy !== 1'b0) begin
            n_bad++;
            $display("FAIL abort_no_replay: got state=%0d clk=%b busy=%b, want 0 1 0", state, clk_fpga, busy);
        end
    endtask

    task automatic test_reset_mid_play();
        send(1, 8'hA0);
        for (int k = 0; k < 4; k++) send_sample(ccd_s[k]);
        send(1, 8'h55);
        repeat (20) @(negedge sys_clk);
        rst = 1'b1;
        @(negedge sys_clk);
        rst = 1'b0;
        n_cmp++;
        if (pins !== IDLE_PINS || dac_d !== 14'd0 || state !== 2'd0 || busy !== 1'b0 || done !== 1'b0) begin
            n_bad++;
            $display("FAIL rst_mid_pins: got pins=%b dac=%h state=%0d busy=%b done=%b, want pins=%b dac=0 state=0 busy=0 done=0",
                     pins, dac_d, state, busy, done, IDLE_PINS);
        end
        n_cmp++;
        if (pat_len !== 4'd0 || overflow !== 1'b0) begin
            n_bad++;
            $display("FAIL rst_mid_len: got pat_len=%0d overflow=%b, want 0 0", pat_len, overflow);
        end
        // Cleared config plays as N = 4, one line, black = 0.
        send(1, 8'hA0);
        send_sample(16'h0155);
        send(1, 8'h55);
        for (int c = 1; c <= 8; c++) begin
            @(negedge sys_clk);
            if (c == 5) begin
                n_cmp++;
                if (clk_fpga !== 1'b0 || dac_d !== 14'h155) begin
                    n_bad++;
                    $display("FAIL rst_cfg_cleared: got clk=%b dac=%h, want clk=0 dac=155", clk_fpga, dac_d);
                end
            end
            if (c == 8) begin
                n_cmp++;
                if (done !== 1'b1 || state !== 2'd3) begin
                    n_bad++;
                    $display("FAIL rst_cfg_done: got done=%b state=%0d, want 1 3", done, state);
                end
            end
        end
    endtask

    task automatic test_empty_stop();
        logic saw_low;
        send(1, 8'hA0);
        n_cmp++;
        if (state !== 2'd1) begin
            n_bad++;
            $display("FAIL empty_load: got state=%0d, want 1", state);
        end
        send(1, 8'h55);
        saw_low = (clk_fpga !== 1'b1);
        n_cmp++;
        if (state !== 2'd0 || busy !== 1'b0) begin
            n_bad++;
            $display("FAIL empty_stop_state: got state=%0d busy=%b, want 0 0", state, busy);
        end
        for (int c = 0; c < 10; c++) begin
            @(negedge sys_clk);
            if (clk_fpga !== 1'b1) saw_low = 1'b1;
        end
        n_cmp++;
        if (saw_low !== 1'b0) begin
            n_bad++;
            $display("FAIL empty_stop_clk: got clk low seen=%b, want 0", saw_low);
        end
    endtask

    initial begin
        rst          = 1'b1;
        master_data  = 8'h00;
        cfg_valid    = 1'b0;
        ctrl_valid   = 1'b0;
        sample_valid = 1'b0;
        test_reset();
        test_ccd();
        test_replay();
        test_plain();
        test_overflow();
        test_abort();
        test_reset_mid_play();
        test_empty_stop();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/ccd_pattern_player.md
# ccd_pattern_player

Parametrised successor to the single-shot functional-test DAC driver. It loads a pixel pattern from the byte-wide master stream into an internal RAM, then replays it to the DAC for a programmable number of lines. During replay it generates the CCD timing set (CLK, SHP, SHD, clamp, HD, VD). It sits between the master byte bus and the DAC/SBIS-BOS analog pins, in the `sys_clk` domain.

## Interface
Parameters:
- `DAC_W`, 14, DAC sample width; must be ≤ 16.
- `DEPTH`, 256, pattern RAM depth in samples; must be a power of 2.
- `AW`, `$clog2(DEPTH)`, RAM address width (derived).

Ports:
- `sys_clk`  in  1  sole clock.
- `rst`  in  1  reset; synchronous, active-high.
- `master_data`  in  8  byte from master bus.
- `cfg_valid`  in  1  `master_data` is a config byte.
- `ctrl_valid`  in  1  `master_data` is a command byte.
- `sample_valid`  in  1  `master_data` is a sample byte.
- `dac_d`  out  DAC_W  DAC code.
- `clk_fpga`, `shp_fpga`, `shd_fpga`  out  1 each  pixel clock and sample pulses, active-low.
- `clpdm_fpga`, `clpob_fpga`  out  1 each  clamp; `clpob_fpga` equals `clpdm_fpga`.
- `hd_fpga`, `vd_fpga`  out  1 each  line and frame markers.
- `busy`  out  1  high in LOAD or PLAY.
- `done`  out  1  high in DONE.
- `overflow`  out  1  sticky flag: a sample was dropped because the RAM was full.
- `pat_len`  out  AW+1  number of samples loaded.
- `state`  out  2  debug.

## Operation
- **Config register:** 40-bit shift register. Each `cfg_valid` shifts right 8 bits; the new byte enters at [39:32], so the host sends LSB first. Fields:
  - [DAC_W-1:0] = `black`
  - [23:16] = `N` (half pixel period, in clocks)
  - [31:24] = `blank`
  - [39:32] = `lines`
- **Field rules:**
  - `N` < 4 is treated as 4.
  - `lines` = 0 is treated as 1.
  - Config writes are accepted in any state but take effect only when PLAY is entered.
- **Commands** (`ctrl_valid`; all other values ignored):
  - `0xA0|m` (m = bit0; 1 = plain-ADC mode, 0 = CCD mode), from IDLE or DONE: go to LOAD, clear `pat_len` and `overflow`, clear byte phase.
  - `0x55`, in LOAD: go to PLAY if `pat_len` > 0, else go to IDLE.
  - `0x5B`, in DONE: replay, i.e. go to PLAY with the same RAM contents.
  - `0x5A`, in any state: abort to IDLE.
- **LOAD:**
  - Byte pairs form one sample, low byte first: sample = {hi, lo}[DAC_W-1:0].
  - Each sample is written at address `pat_len`, then `pat_len` increments.
  - When `pat_len` = DEPTH, further samples are dropped and `overflow` is set.
- **PLAY counters:**
  - `inner` runs 0..2N-1.
  - `pix` runs 0..pat_len-1 and advances when `inner` wraps.
  - `line` runs 0..lines-1 and advances when `pix` wraps.
  - After the last `inner` of the last pixel of the last line, go to DONE.
- **Outputs in PLAY** (all registered; "at k" means updated on the edge where `inner` == k):
  - `clk_fpga`: 1 at 0, 0 at N.
  - `shp_fpga`: 0 at N/4, 1 at 3N/4.
  - `shd_fpga`: 0 at N + N/4, 1 at N + 3N/4. Divisions are truncating.
  - `dac_d`, CCD mode: `black` at 0, then `ram[pix]` at N.
  - `dac_d`, plain mode: `ram[pix]` at 0.
  - At 0: `clpdm_fpga` = (pix < pat_len - blank); it stays 0 whenever `blank` ≥ `pat_len`.
  - At 0: `hd_fpga` = (pix == 0).
  - At 0: `vd_fpga` = (line == 0).
- **Idle levels** (IDLE, LOAD, DONE; also after abort and reset):
  - `clk_fpga` = `shp_fpga` = `shd_fpga` = 1.
  - `clpdm_fpga`, `hd_fpga`, `vd_fpga` = 0.
  - `dac_d` = 0.
- **Reset values:** state = IDLE, all counters 0, config register 0, `pat_len` 0, `overflow` 0, outputs at idle levels, `busy` = `done` = 0. RAM contents are undefined after reset.

## Timing
- Pixel period is 2N clocks. A line is `pat_len`·2N clocks; a frame is `lines`·`pat_len`·2N clocks.
- Command-to-PLAY: the first edge with `inner` == 0 is the cycle after the `0x55`/`0x5B` command is sampled.
- RAM read has 1-cycle latency. The implementation prefetches `ram[pix+1]` during the current pixel, so there are no bubbles between pixels.
- A command and a sample/config byte in the same cycle: the command wins and the byte is dropped. Only one of the three valids is asserted by the master bus; the bench checks this.
- Abort mid-PLAY: idle levels apply on the next edge, and `line`/`pix`/`inner` clear.
- Synchronous `rst` mid-operation: same as abort, plus the config register, `pat_len` and `overflow` clear.
- `sample_valid` outside LOAD: ignored.

## Structure
- Shared defines/package `ccd_pkg` holds:
  - state encodings: IDLE = 0, LOAD = 1, PLAY = 2, DONE = 3;
  - command constants: `CMD_START` = 0xA0, `CMD_STOP` = 0x55, `CMD_ABORT` = 0x5A, `CMD_REPLAY` = 0x5B;
  - config field offsets.
- One sub-module, `pattern_ram`: simple dual-port, DEPTH × DAC_W, synchronous write, registered read, inferred memory.
- The top level holds the FSM, counters, byte assembler and output registers.

## Test plan
- **CCD mode:** config black = 0x100, N = 8, blank = 1, lines = 2; load 4 samples 0x111..0x444; start 0xA0, stop 0x55.
  - `dac_d` per pixel alternates 0x100 / 0x111, 0x100 / 0x222, and so on.
  - `clk_fpga` falls 8 clocks after it rises.
  - `shp_fpga` is low for clocks 2..5 of each pixel; `shd_fpga` is low for clocks 10..13.
  - `clpdm_fpga` is high for pixels 0-2 only; `hd_fpga` is high on pixel 0; `vd_fpga` is high on line 0 only.
  - DONE is reached after exactly 128 clocks.
- **Plain mode (0xA1):** `dac_d` changes only at `inner` = 0, and sample values appear in load order with no repeats or gaps.
- **Overflow:** with DEPTH = 8, load 10 samples. Expect `pat_len` = 8, `overflow` = 1, and replay shows the first 8 samples.
- **Replay and edge configs:** `0x5B` from DONE replays identically. With N = 0 the block behaves as N = 4. With lines = 0 exactly one line plays.
- **Abort:** `0x5A` at line 1, pixel 2. Next cycle shows idle levels and `busy` = 0; a subsequent `0x5B` is ignored (state stays IDLE).
- **Reset and empty stop:** `rst` pulse mid-PLAY → all outputs at reset values on the next edge. `0x55` with `pat_len` = 0 returns to IDLE without toggling `clk_fpga`.
